// File: rtl/pc_ctx_pkg.sv
// Shared definitions for the multi-context program counter bank:
// OS context ops, the OS context index and a constant clog2 helper.
package pc_ctx_pkg;

  localparam logic [1:0] PC_OP_NONE   = 2'b00;
  localparam logic [1:0] PC_OP_SWITCH = 2'b01;
  localparam logic [1:0] PC_OP_SETPC  = 2'b10;
  localparam logic [1:0] PC_OP_RESUME = 2'b11;

  localparam int unsigned OS_CTX = 0;

  // Ceiling log2, used to size the context index from the context count.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/pc_next_logic.sv
// Next-PC resolution for the active context. Purely combinational.
// When the context is halted, or halts on this instruction, the caller holds
// the PC register; next_pc is then don't-care and simply mirrors address.
module pc_next_logic #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] i_address,
  input  logic                  i_jmp,
  input  logic                  i_beq,
  input  logic                  i_bneq,
  input  logic                  i_hlt,
  input  logic                  i_zero,
  input  logic                  i_halted_cur,
  output logic [DATA_WIDTH-1:0] o_next_pc,
  output logic                  o_set_halt
);

  logic [DATA_WIDTH-1:0] w_addr_inc;

  // Sequential fall-through, wrapping at the top of the address space.
  assign w_addr_inc = i_address + DATA_WIDTH'(1);

  // Priority decode: bneq, beq, jmp, hlt, then fall-through.
  always_comb begin
    o_next_pc  = w_addr_inc;
    o_set_halt = 1'b0;
    if (i_halted_cur) begin
      o_next_pc = i_address;
    end else if (i_bneq) begin
      o_next_pc = i_zero ? w_addr_inc : i_address;
    end else if (i_beq) begin
      o_next_pc = i_zero ? i_address : w_addr_inc;
    end else if (i_jmp) begin
      o_next_pc = i_address;
    end else if (i_hlt) begin
      o_next_pc  = i_address;
      o_set_halt = 1'b1;
    end
  end

endmodule

// File: rtl/pc_context_bank.sv
// Multi-context program counter bank for the fetch stage.
// Context 0 is the OS; it alone may switch, set the PC of, or resume other
// contexts. User contexts return to the OS on hlt or when their quantum of
// enabled cycles runs out (the latter flagged by a one-cycle preempt pulse).
module pc_context_bank
  import pc_ctx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_CTX    = 4,
  parameter int unsigned CTX_W      = clog2(NUM_CTX),
  parameter int unsigned QUANTUM_W  = 8
) (
  input  logic                  clk_write,
  input  logic                  rst,
  input  logic                  i_en,
  input  logic                  i_jmp,
  input  logic                  i_beq,
  input  logic                  i_bneq,
  input  logic                  i_hlt,
  input  logic                  i_zero,
  input  logic [1:0]            i_pc_op,
  input  logic [CTX_W-1:0]      i_target_ctx,
  input  logic [DATA_WIDTH-1:0] i_address,
  input  logic [DATA_WIDTH-1:0] i_stored_pc,
  input  logic [QUANTUM_W-1:0]  i_quantum,
  output logic [DATA_WIDTH-1:0] o_prog_count,
  output logic [CTX_W-1:0]      o_active_ctx,
  output logic [DATA_WIDTH-1:0] o_ctx_pc,
  output logic [NUM_CTX-1:0]    o_halted,
  output logic                  o_preempt
);

  logic [DATA_WIDTH-1:0] r_pc [NUM_CTX];
  logic [NUM_CTX-1:0]    r_halted;
  logic [CTX_W-1:0]      r_active;
  logic [QUANTUM_W-1:0]  r_qcnt;
  logic                  r_preempt;

  logic [DATA_WIDTH-1:0] w_next_pc;
  logic                  w_set_halt;
  logic                  w_halted_cur;
  logic                  w_hold;
  logic                  w_is_os;
  logic                  w_target_ok;
  logic                  w_target_user;
  logic                  w_op_ok;
  logic                  w_do_switch;
  logic                  w_do_setpc;
  logic                  w_do_resume;
  logic                  w_user_halt;
  logic                  w_expire;
  logic                  w_preempt;

  // Out-of-range targets only exist when NUM_CTX is not a power of two.
  if (NUM_CTX == (1 << CTX_W)) begin : g_target_full
    assign w_target_ok = 1'b1;
  end else begin : g_target_chk
    assign w_target_ok = (32'(i_target_ctx) < NUM_CTX);
  end

  assign w_is_os      = (r_active == CTX_W'(OS_CTX));
  assign w_halted_cur = r_halted[r_active];

  pc_next_logic #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_pc_next_logic (
    .i_address    (i_address),
    .i_jmp        (i_jmp),
    .i_beq        (i_beq),
    .i_bneq       (i_bneq),
    .i_hlt        (i_hlt),
    .i_zero       (i_zero),
    .i_halted_cur (w_halted_cur),
    .o_next_pc    (w_next_pc),
    .o_set_halt   (w_set_halt)
  );

  // A halted context, or one halting now, keeps its PC.
  assign w_hold = w_halted_cur | w_set_halt;

  // OS ops; ops aimed at context 0 are no-ops (switch-to-self changes nothing).
  assign w_target_user = (i_target_ctx != CTX_W'(OS_CTX));
  assign w_op_ok       = w_is_os & w_target_ok & w_target_user;
  assign w_do_switch   = w_op_ok & (i_pc_op == PC_OP_SWITCH);
  assign w_do_setpc    = w_op_ok & (i_pc_op == PC_OP_SETPC);
  assign w_do_resume   = w_op_ok & (i_pc_op == PC_OP_RESUME);

  // A user hlt returns to the OS silently, even if the quantum expires too.
  assign w_user_halt = ~w_is_os & w_set_halt;
  assign w_expire    = ~w_is_os & (i_quantum != '0) &
                       (r_qcnt == (i_quantum - QUANTUM_W'(1)));
  assign w_preempt   = w_expire & ~w_user_halt;

  assign o_prog_count = r_pc[r_active];
  assign o_ctx_pc     = w_target_ok ? r_pc[i_target_ctx] : '0;
  assign o_active_ctx = r_active;
  assign o_halted     = r_halted;
  assign o_preempt    = r_preempt;

  // PC bank, halt flags, active context, quantum counter and preempt pulse.
  always_ff @(posedge clk_write) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_CTX); i++) begin
        r_pc[i] <= '0;
      end
      r_halted  <= '0;
      r_active  <= CTX_W'(OS_CTX);
      r_qcnt    <= '0;
      r_preempt <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      if (i_en) begin
        if (!w_hold) begin
          r_pc[r_active] <= w_next_pc;
        end
        // setpc only fires while the OS runs and never targets it, so the
        // two PC writes always land on different entries.
        if (w_do_setpc) begin
          r_pc[i_target_ctx] <= i_stored_pc;
        end
        if (w_set_halt) begin
          r_halted[r_active] <= 1'b1;
        end
        if (w_do_resume) begin
          r_halted[i_target_ctx] <= 1'b0;
        end
        if (w_is_os) begin
          if (w_do_switch) begin
            r_active <= i_target_ctx;
            r_qcnt   <= '0;
          end
        end else if (w_user_halt || w_expire) begin
          r_active  <= CTX_W'(OS_CTX);
          r_qcnt    <= '0;
          r_preempt <= w_preempt;
        end else begin
          r_qcnt <= r_qcnt + QUANTUM_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_context_bank.sv
// Directed bench for pc_context_bank: a behavioural model of the context
// bank is stepped on every clock and compared against the DUT on each
// falling edge, alongside hand-computed literal expectations.
module tb_pc_context_bank;
  import pc_ctx_pkg::*;

  localparam int DW = 32;
  localparam int NC = 4;
  localparam int CW = 2;
  localparam int QW = 8;

  logic          clk_write = 1'b0;
  logic          rst;
  logic          en;
  logic          jmp;
  logic          beq;
  logic          bneq;
  logic          hlt;
  logic          zero;
  logic [1:0]    pc_op;
  logic [CW-1:0] target_ctx;
  logic [DW-1:0] address;
  logic [DW-1:0] stored_pc;
  logic [QW-1:0] quantum;

  logic [DW-1:0] prog_count;
  logic [CW-1:0] active_ctx;
  logic [DW-1:0] ctx_pc;
  logic [NC-1:0] halted;
  logic          preempt;

  int n_total = 0;
  int n_pass  = 0;
  bit chk_on  = 1'b0;

  // Model state
  logic [DW-1:0] m_pc [NC];
  logic [NC-1:0] m_halted;
  int            m_active;
  int            m_cnt;
  bit            m_preempt;

  pc_context_bank #(
    .DATA_WIDTH (DW),
    .NUM_CTX    (NC),
    .CTX_W      (CW),
    .QUANTUM_W  (QW)
  ) dut (
    .clk_write    (clk_write),
    .rst          (rst),
    .i_en         (en),
    .i_jmp        (jmp),
    .i_beq        (beq),
    .i_bneq       (bneq),
    .i_hlt        (hlt),
    .i_zero       (zero),
    .i_pc_op      (pc_op),
    .i_target_ctx (target_ctx),
    .i_address    (address),
    .i_stored_pc  (stored_pc),
    .i_quantum    (quantum),
    .o_prog_count (prog_count),
    .o_active_ctx (active_ctx),
    .o_ctx_pc     (ctx_pc),
    .o_halted     (halted),
    .o_preempt    (preempt)
  );

  always #5 clk_write = ~clk_write;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  // One clock edge of the specified behaviour, using the inputs held at the edge.
  task automatic model_step();
    int  c;
    int  t;
    bit  halt_now;
    if (rst) begin
      for (int i = 0; i < NC; i++) m_pc[i] = '0;
      m_halted  = '0;
      m_active  = 0;
      m_cnt     = 0;
      m_preempt = 1'b0;
      return;
    end
    m_preempt = 1'b0;
    if (!en) return;
    c        = m_active;
    t        = int'(target_ctx);
    halt_now = 1'b0;
    if (!m_halted[c]) begin
      if (bneq)      m_pc[c] = zero ? address + 32'd1 : address;
      else if (beq)  m_pc[c] = zero ? address : address + 32'd1;
      else if (jmp)  m_pc[c] = address;
      else if (hlt) begin
        m_halted[c] = 1'b1;
        halt_now    = 1'b1;
      end
      else           m_pc[c] = address + 32'd1;
    end
    if (c == 0) begin
      if (t < NC && t != 0) begin
        case (pc_op)
          PC_OP_SWITCH: begin m_active = t; m_cnt = 0; end
          PC_OP_SETPC:  m_pc[t] = stored_pc;
          PC_OP_RESUME: m_halted[t] = 1'b0;
          default: ;
        endcase
      end
    end else if (halt_now) begin
      m_active = 0;
      m_cnt    = 0;
    end else if (quantum != 0 && m_cnt == int'(quantum) - 1) begin
      m_active  = 0;
      m_cnt     = 0;
      m_preempt = 1'b1;
    end else begin
      m_cnt = (m_cnt + 1) % 256;
    end
  endtask

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk_write) begin
    if (chk_on) begin
      check("prog_count", 64'(prog_count), 64'(m_pc[m_active]));
      check("active_ctx", 64'(active_ctx), 64'(m_active));
      check("halted",     64'(halted),     64'(m_halted));
      check("preempt",    64'(preempt),    64'(m_preempt));
      check("ctx_pc",     64'(ctx_pc),     64'(m_pc[target_ctx]));
    end
  end

  task automatic cyc();
    @(posedge clk_write);
    model_step();
    #1;
  endtask

  task automatic idle();
    jmp   = 1'b0;
    beq   = 1'b0;
    bneq  = 1'b0;
    hlt   = 1'b0;
    zero  = 1'b0;
    pc_op = PC_OP_NONE;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; idle();
    target_ctx = '0; address = '0; stored_pc = '0; quantum = '0;
    cyc();
    check("lit_rst_pc",      64'(prog_count), 64'd0);
    check("lit_rst_ctx",     64'(active_ctx), 64'd0);
    check("lit_rst_halted",  64'(halted),     64'd0);
    check("lit_rst_preempt", 64'(preempt),    64'd0);
    rst = 1'b0; chk_on = 1'b1; en = 1'b1;

    // OS runs sequentially
    for (int i = 0; i < 3; i++) begin
      address = 32'(i);
      cyc();
    end
    check("lit_os_pc3", 64'(prog_count), 64'd3);
    check("lit_os_ctx", 64'(active_ctx), 64'd0);

    // setpc then switch to context 2
    address = 32'd3; pc_op = PC_OP_SETPC; target_ctx = 2'd2; stored_pc = 32'h100;
    cyc();
    check("lit_setpc_ctx2", 64'(ctx_pc),     64'h100);
    check("lit_os_pc4",     64'(prog_count), 64'd4);
    address = 32'd4; pc_op = PC_OP_SWITCH;
    cyc(); idle();
    check("lit_switch_ctx", 64'(active_ctx), 64'd2);
    check("lit_switch_pc",  64'(prog_count), 64'h100);
    target_ctx = 2'd0; #1;
    check("lit_os_pc5", 64'(ctx_pc), 64'd5);

    // Branches in context 2
    beq = 1'b1; zero = 1'b1; address = 32'h40;
    cyc();
    check("lit_beq_taken", 64'(prog_count), 64'h40);
    beq = 1'b0; bneq = 1'b1;
    cyc();
    check("lit_bneq_zero", 64'(prog_count), 64'h41);
    beq = 1'b1; bneq = 1'b1; zero = 1'b0; address = 32'h50;
    pc_op = PC_OP_SETPC; target_ctx = 2'd1; stored_pc = 32'hDEAD;
    cyc();
    check("lit_bneq_wins",       64'(prog_count), 64'h50);
    check("lit_user_op_ignored", 64'(ctx_pc),     64'd0);
    idle(); jmp = 1'b1; address = 32'h77;
    cyc();
    check("lit_jmp", 64'(prog_count), 64'h77);
    idle(); hlt = 1'b1;
    cyc(); idle();
    check("lit_hlt2_halted",  64'(halted),     64'b0100);
    check("lit_hlt2_ctx",     64'(active_ctx), 64'd0);
    check("lit_hlt2_preempt", 64'(preempt),    64'd0);

    // Quantum preemption in context 1
    address = 32'd5; pc_op = PC_OP_SWITCH; target_ctx = 2'd1; quantum = 8'd3;
    cyc(); idle();
    for (int i = 0; i < 3; i++) begin
      address = 32'(i);
      cyc();
      if (i == 1) check("lit_q_not_yet", 64'(active_ctx), 64'd1);
    end
    check("lit_q_ctx",     64'(active_ctx), 64'd0);
    check("lit_q_preempt", 64'(preempt),    64'd1);
    check("lit_q_os_pc",   64'(prog_count), 64'd6);
    en = 1'b0;
    cyc();
    check("lit_en0_preempt", 64'(preempt),    64'd0);
    check("lit_en0_pc",      64'(prog_count), 64'd6);
    en = 1'b1;

    // quantum=0 never preempts; hlt on the expiry edge stays silent
    quantum = 8'd0; address = 32'd6; pc_op = PC_OP_SWITCH; target_ctx = 2'd1;
    cyc(); idle();
    for (int i = 0; i < 5; i++) begin
      address = 32'd3 + 32'(i);
      cyc();
    end
    check("lit_q0_ctx", 64'(active_ctx), 64'd1);
    check("lit_q0_pc",  64'(prog_count), 64'd8);
    quantum = 8'd6; hlt = 1'b1; address = 32'd8;
    cyc(); idle();
    check("lit_hlt1_halted",  64'(halted),     64'b0110);
    check("lit_hlt1_ctx",     64'(active_ctx), 64'd0);
    check("lit_hlt1_preempt", 64'(preempt),    64'd0);

    // Switch to halted context 1 without resume: frozen, then preempted
    quantum = 8'd2; address = 32'd7; pc_op = PC_OP_SWITCH; target_ctx = 2'd1;
    cyc(); idle();
    jmp = 1'b1; address = 32'h999;
    cyc();
    check("lit_frozen_pc", 64'(prog_count), 64'd8);
    cyc(); idle();
    check("lit_frozen_ctx",     64'(active_ctx), 64'd0);
    check("lit_frozen_preempt", 64'(preempt),    64'd1);

    // Resume and rerun context 1
    quantum = 8'd0; address = 32'd8; pc_op = PC_OP_RESUME; target_ctx = 2'd1;
    cyc();
    check("lit_resume_halted", 64'(halted), 64'b0100);
    address = 32'd9; pc_op = PC_OP_SWITCH;
    cyc(); idle();
    address = 32'h20;
    cyc();
    check("lit_resumed_pc", 64'(prog_count), 64'h21);
    address = 32'hFFFF_FFFF;
    cyc();
    check("lit_wrap", 64'(prog_count), 64'd0);
    en = 1'b0; jmp = 1'b1; address = 32'h55;
    cyc(); idle();
    check("lit_hold_pc",  64'(prog_count), 64'd0);
    check("lit_hold_ctx", 64'(active_ctx), 64'd1);

    // Reset mid-user-context with en=0
    rst = 1'b1; en = 1'b0; target_ctx = 2'd2;
    cyc();
    check("lit_rst2_ctx",    64'(active_ctx), 64'd0);
    check("lit_rst2_halted", 64'(halted),     64'd0);
    check("lit_rst2_ctxpc",  64'(ctx_pc),     64'd0);
    rst = 1'b0; en = 1'b1; address = 32'h10;
    cyc();
    check("lit_post_rst_pc", 64'(prog_count), 64'h11);
    @(negedge clk_write);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_context_bank.md
Name: pc_context_bank

Overview:
- Multi-context program counter for the BM_CORE fetch stage.
- Holds NUM_CTX independent PCs: context 0 is the OS, contexts 1..NUM_CTX-1 are hardware processes.
- Resolves jump, beq, bneq and halt for the active context, and lets the OS set, switch to and resume other contexts.
- Adds per-context halt state and quantum-based preemption back to the OS; drives the instruction-memory address.

Parameters:
- DATA_WIDTH, 32, PC and address width.
- NUM_CTX, 4, number of contexts including OS (>=2).
- CTX_W, 2, context index width, equal to clog2(NUM_CTX).
- QUANTUM_W, 8, width of the preemption quantum and counter.

Ports:
- clk_write  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  advance enable; when 0 all state holds.
- jmp  in  1  unconditional jump to address.
- beq  in  1  branch-if-equal instruction.
- bneq  in  1  branch-if-not-equal instruction.
- hlt  in  1  halt instruction.
- zero  in  1  ALU zero flag.
- pc_op  in  2  OS context op: 00 none, 01 switch, 10 setpc, 11 resume.
- target_ctx  in  CTX_W  context addressed by pc_op and by the ctx_pc read port.
- address  in  DATA_WIDTH  current instruction address / branch target.
- stored_pc  in  DATA_WIDTH  value written by setpc.
- quantum  in  QUANTUM_W  preemption quantum; 0 disables preemption.
- prog_count  out  DATA_WIDTH  PC of the active context (combinational mux of registers).
- active_ctx  out  CTX_W  currently executing context.
- ctx_pc  out  DATA_WIDTH  PC of target_ctx (combinational read).
- halted  out  NUM_CTX  per-context halted flags.
- preempt  out  1  one-cycle pulse on the edge that forces a return to the OS.

Behaviour:
- Reset: all PCs 0, active_ctx 0, halted all 0, quantum counter 0, preempt 0. rst overrides every other input, including en=0.
- en=0: no state changes; preempt is 0 the following cycle.
- Next-PC for the active context c, first match wins:
  - bneq & zero -> address+1
  - bneq & !zero -> address
  - beq & zero -> address
  - beq & !zero -> address+1
  - jmp -> address
  - hlt -> hold and set halted[c]
  - otherwise -> address+1
- The +1 wraps modulo 2^DATA_WIDTH.
- A halted active context holds its PC and ignores all branch inputs.
- pc_op is honoured only when active_ctx==0. Otherwise it is ignored.
- setpc: pc[target_ctx] <= stored_pc. If target_ctx==0 it is ignored; the OS's own next-PC wins.
- switch: active_ctx <= target_ctx. The OS PC still takes its normal next-PC on the same edge. Switching to a halted context is allowed; that context stays frozen until resumed.
- resume: halted[target_ctx] <= 0. If target_ctx==0 it is ignored.
- target_ctx >= NUM_CTX: pc_op is ignored and ctx_pc reads 0.
- Quantum counter:
  - Increments on each en edge while active_ctx!=0.
  - Cleared to 0 on any change of active_ctx.
  - When active_ctx!=0, quantum!=0 and counter==quantum-1 at an en edge: the user PC updates normally, active_ctx <= 0, counter <= 0, preempt=1 for exactly one cycle.
- User-context hlt: sets halted[c] and returns active_ctx <= 0 on the same edge. preempt stays 0, even if the quantum also expires on that edge.
- Latency: prog_count reflects a new PC or a context switch one cycle after the edge. ctx_pc and prog_count are zero-latency reads of the registers.

Decomposition:
- Package pc_ctx_pkg holds:
  - pc_op encodings PC_OP_NONE/SWITCH/SETPC/RESUME.
  - OS_CTX = 0.
  - A function clog2 for CTX_W.
- One natural sub-module: pc_next_logic, combinational. Inputs: address, jmp, beq, bneq, hlt, zero, halted_cur. Outputs: next_pc, set_halt.
- The top level holds the PC register array, the halted vector, the active_ctx register and the quantum counter.

Test Plan:
- Reset then 3 en cycles with address=0,1,2 and no flags -> prog_count=1,2,3; active_ctx=0; halted=0000.
- OS setpc target=2, stored_pc=0x100; next cycle switch target=2 -> ctx_pc(2)=0x100, active_ctx=2, prog_count=0x100; OS PC advanced by 1 on each of those edges.
- In ctx 2: beq, zero=1, address=0x40 -> pc=0x40. Then bneq, zero=1, address=0x40 -> pc=0x41. Then beq and bneq both 1, zero=0 -> pc=address (bneq wins).
- quantum=3 in ctx 1 -> after the 3rd en edge active_ctx=0 and preempt high for exactly one cycle. With quantum=0, the same run never preempts.
- ctx 1 executes hlt -> halted[1]=1, active_ctx=0, preempt=0. OS switches to 1 without resume -> PC frozen. OS resume target=1, then switch -> ctx 1 advances again.
- Address 0xFFFFFFFF, no flags -> PC wraps to 0. rst asserted mid-user-context with en=0 -> all PCs 0 and active_ctx=0 on that edge.
